// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, one-deep output holding register.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (sense set by PARITY_ODD).
module uart_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_cpb
    $error("uart_rx: CLKS_PER_BIT must be even, 4..65535");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t                 state;
  logic                   rx_meta, rxs;
  logic [CW-1:0]          clk_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   done;
  logic                   ferr_q;
  logic                   perr_next;
  logic                   accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic pbit_q;
  assign perr_next = (((^shreg) ^ pbit_q) != ODD);
`else
  assign perr_next = 1'b0;
`endif

  // done is a one-cycle pulse the cycle after the stop sample; it drives the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      done    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbit_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        clk_cnt <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            if (!rxs) state <= START;
          end
          START: begin
            if (clk_cnt == HALF_M1) begin
              clk_cnt <= '0;
              state   <= rxs ? IDLE : DATA;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
          DATA: begin
            if (clk_cnt == FULL_M1) begin
              clk_cnt <= '0;
              shreg   <= {rxs, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (clk_cnt == FULL_M1) begin
              clk_cnt <= '0;
              pbit_q  <= rxs;
              state   <= STOP;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
`endif
          STOP: begin
            if (clk_cnt == FULL_M1) begin
              clk_cnt <= '0;
              done    <= 1'b1;
              ferr_q  <= ~rxs;
              state   <= rxs ? IDLE : BREAK;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
          BREAK: begin
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign accept = valid && ready;

  // A completion can only land if the register is free or being emptied this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (done) begin
      if (!valid || ready) begin
        data_out   <= shreg;
        frame_err  <= ferr_q;
        parity_err <= perr_next;
        valid      <= 1'b1;
        if (accept) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (accept) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a negedge monitor pops on handshake.
module tb_uart_rx;
  localparam int DB  = 8;
  localparam int CPB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          en = 1'b1;
  logic          ready = 1'b1;
  logic [DB-1:0] data_out;
  logic          valid, frame_err, parity_err, overrun;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_rx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .en(en),
    .data_out(data_out), .valid(valid), .ready(ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Parity errors can only be reported when the parity feature is built in.
  function automatic logic exp_pe(input logic pflip);
    logic r;
    r = pflip;
`ifndef UART_RX_PARITY_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  task automatic push(input logic [7:0] d, input logic fe, input logic pflip, input logic ov);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = exp_pe(pflip);
    e.ov = ov;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  // pflip inverts the correct even-parity bit; rx is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ pflip);
`else
    if (pflip) rx = 1'b0;
`endif
    send_bit(stop);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_parity_err"}, parity_err, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid && ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got frame %0h, expected no frame", data_out);
      end else begin
        e = q.pop_front();
        check("data_out", data_out, e.d);
        check("frame_err", frame_err, e.fe);
        check("parity_err", parity_err, e.pe);
        check("overrun", overrun, e.ov);
      end
    end
  end

  initial begin
    tick(3);
    check_zero("reset");
    rst_n = 1'b1;
    tick(5);

    push(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(20);

    // short low glitch must be rejected in START
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    push(8'h5A, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(20);

    // bad stop bit, then line held low: one frame_err frame, no restart until high
    push(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(40);
    rx = 1'b1;
    tick(40);
    push(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(20);

    // overrun: second frame dropped while first is unread
    ready = 1'b0;
    push(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0);
    tick(20);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(20);
    check("ovr_valid_held", valid, 1);
    check("ovr_data_held", data_out, 8'h11);
    check("ovr_flag_set", overrun, 1);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check("ovr_valid_fell", valid, 0);
    check("ovr_flag_cleared", overrun, 0);
    ready = 1'b1;
    tick(10);

    // handshake completes with en low; frames sent while disabled are ignored
    ready = 1'b0;
    push(8'h44, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    tick(20);
    en = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0);
    tick(5);
    ready = 1'b1;
    tick(3);
    en = 1'b1;
    tick(10);

    // en dropped mid-frame aborts silently
    fork
      send_frame(8'h0F, 1'b1, 1'b0);
      begin
        tick(60);
        en = 1'b0;
      end
    join
    tick(5);
    en = 1'b1;
    tick(40);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight: even parity bit 0 is wrong, 1 is right
    push(8'h07, 1'b0, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(20);
    push(8'h07, 1'b0, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(20);
`endif

    // reset during data bit 3 of 0xFF, then 0x81 is the only delivery
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        tick(CPB + CPB * 3 + CPB / 2);
        rst_n = 1'b0;
        tick(3);
        check_zero("midreset");
        rst_n = 1'b1;
      end
    join
    tick(20);
    push(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(20);

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit period, even, legal 4..65535.
REQ-003 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only under UART_RX_PARITY_EN.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx  input  1  serial line, asynchronous, idles high.
REQ-007 SHALL have port en  input  1  receive enable.
REQ-008 SHALL have port data_out  output  DATA_BITS  received word, bit 0 first on line.
REQ-009 SHALL have port valid  output  1  data_out and status flags hold an unread frame.
REQ-010 SHALL have port ready  input  1  consumer accepts frame when valid&&ready.
REQ-011 SHALL have port frame_err  output  1  stop bit sampled 0 for current frame.
REQ-012 SHALL have port parity_err  output  1  parity mismatch for current frame.
REQ-013 SHALL have port overrun  output  1  sticky, a completed frame was dropped.

Function
REQ-014 SHALL pass rx through a 2-flop synchroniser; all decisions use the synchronised value rxs.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 IDLE: rxs==0 -> START, bit counter cleared.
REQ-017 START: sample rxs CLKS_PER_BIT/2 cycles after entry; 0 -> DATA; 1 -> IDLE (glitch rejected, no flags, no valid).
REQ-018 DATA: sample every CLKS_PER_BIT cycles, shift LSB-first; after DATA_BITS samples -> PARITY if enabled, else STOP.
REQ-019 PARITY: one sample CLKS_PER_BIT cycles later, compare per REQ-030, -> STOP.
REQ-020 STOP: sample after CLKS_PER_BIT cycles; 1 -> IDLE; 0 -> BREAK with frame_err for this frame.
REQ-021 BREAK: wait until rxs==1, then -> IDLE; no start detection while in BREAK.
REQ-022 Frame completion SHALL occur on the cycle after the stop sample: data_out, frame_err, parity_err loaded, valid=1.
REQ-023 valid SHALL hold, with data_out and error flags stable, until the cycle valid&&ready; it deasserts the following cycle.
REQ-024 Completion while valid==1 and ready==0: new frame dropped, old data/flags retained, overrun=1.
REQ-025 Completion in the same cycle as valid&&ready: new frame loaded, valid stays 1, no overrun.
REQ-026 overrun SHALL clear on a valid&&ready handshake in which no new frame is dropped.
REQ-027 en==0 SHALL force IDLE and clear counters synchronously, abort any in-flight frame silently, leave valid/data_out/flags unchanged; handshakes still complete.
REQ-028 Counters SHALL be sized $clog2(CLKS_PER_BIT) and $clog2(DATA_BITS+1) and never wrap within a frame.

Reset
REQ-029 rst_n low SHALL asynchronously set state IDLE, counters 0, synchroniser flops 1, data_out 0, valid 0, frame_err 0, parity_err 0, overrun 0; release mid-frame resumes in IDLE.

Configuration
REQ-030 With UART_RX_PARITY_EN defined: PARITY state present, one parity bit follows data, parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD.
REQ-031 Without UART_RX_PARITY_EN: PARITY state and logic absent, DATA -> STOP directly, parity_err tied 0.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-032 Frame 0xA5, stop=1, ready=1 -> one valid pulse, data_out=0xA5, frame_err=0, parity_err=0, overrun=0.
REQ-033 rx low for 4 cycles, then high -> no valid, FSM back in IDLE, next frame 0x5A received correctly.
REQ-034 Frame 0x3C with stop=0, rx held low 40 cycles -> valid, data_out=0x3C, frame_err=1; no start detected until rx returns high.
REQ-035 Frames 0x11 then 0x22 with ready=0 -> data_out=0x11, overrun=1; ready pulse -> valid falls, overrun clears.
REQ-036 UART_RX_PARITY_EN, PARITY_ODD=0: frame 0x07 with parity bit 0 -> parity_err=1; parity bit 1 -> parity_err=0.
REQ-037 rst_n low at data bit 3 of 0xFF, then frame 0x81 -> outputs 0 during reset, only 0x81 delivered.
